// File: rtl/debug_pkg.sv
// Constants and state encoding shared by the debug frame receiver and the encoder side.
package debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DH   = 3'd1,
        ST_DL   = 3'd2,
        ST_SH   = 3'd3,
        ST_SL   = 3'd4,
        ST_EOF  = 3'd5
    } state_t;

    localparam logic [7:0] SOF_BYTE = 8'h24;
    localparam logic [7:0] LF_BYTE  = 8'h0A;

endpackage

// File: rtl/gap_timer.sv
// Counts idle clocks between bytes of a frame; expired flags the final clock of the allowed gap.
module gap_timer #(
    parameter logic [25:0] TIMEOUT_CYCLES = 26'd1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [25:0] cnt_q;
    logic [25:0] cnt_d;

    assign expired = enable && (cnt_q == (TIMEOUT_CYCLES - 26'd1));

    // next count: cleared by a byte or on expiry, otherwise advance while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clear || expired) begin
            cnt_d = 26'd0;
        end else if (enable) begin
            cnt_d = cnt_q + 26'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= 26'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/debug_frame_rx.sv
// Decodes $-delimited debug frames (SOF, dest16, src16, SOF) from a UART rx buffer
// and publishes the addresses of the last good frame.
module debug_frame_rx #(
    parameter logic [25:0] TIMEOUT_CYCLES = 26'd1000000,
    parameter logic [7:0]  SOF_BYTE       = debug_pkg::SOF_BYTE
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rdata,
    input  logic        i_rready,
    output logic        o_rreq,
    output logic [15:0] o_dest_addr,
    output logic [15:0] o_src_addr,
    output logic        o_frame_valid,
    output logic        o_frame_err,
    output logic [7:0]  o_frame_cnt,
    output logic        o_busy
);

    debug_pkg::state_t state_q, state_d;
    logic [15:0] dest_sh_q, dest_sh_d, src_sh_q, src_sh_d;
    logic [15:0] dest_q, dest_d, src_q, src_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d, err_q, err_d, busy_q, busy_d;
    logic        accept_s, timeout_s, in_idle_s;

    assign accept_s  = i_rready;
    assign in_idle_s = (state_q == debug_pkg::ST_IDLE);

    gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .clear   (accept_s || in_idle_s),
        .enable  (!accept_s && !in_idle_s),
        .expired (timeout_s)
    );

    // frame FSM next state and registered-output next values
    always_comb begin
        state_d   = state_q;
        dest_sh_d = dest_sh_q;
        src_sh_d  = src_sh_q;
        dest_d    = dest_q;
        src_d     = src_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        if (accept_s) begin
            case (state_q)
                debug_pkg::ST_IDLE: begin
                    if (i_rdata == SOF_BYTE) begin
                        state_d = debug_pkg::ST_DH;
                    end else begin
                        state_d = debug_pkg::ST_IDLE;
                    end
                end
                debug_pkg::ST_DH: begin
                    dest_sh_d[15:8] = i_rdata;
                    state_d         = debug_pkg::ST_DL;
                end
                debug_pkg::ST_DL: begin
                    dest_sh_d[7:0] = i_rdata;
                    state_d        = debug_pkg::ST_SH;
                end
                debug_pkg::ST_SH: begin
                    src_sh_d[15:8] = i_rdata;
                    state_d        = debug_pkg::ST_SL;
                end
                debug_pkg::ST_SL: begin
                    src_sh_d[7:0] = i_rdata;
                    state_d       = debug_pkg::ST_EOF;
                end
                debug_pkg::ST_EOF: begin
                    // a bad terminator is dropped, not reused as the next SOF
                    if (i_rdata == SOF_BYTE) begin
                        dest_d  = dest_sh_q;
                        src_d   = src_sh_q;
                        cnt_d   = cnt_q + 8'd1;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = debug_pkg::ST_IDLE;
                end
                default: begin
                    state_d = debug_pkg::ST_IDLE;
                end
            endcase
        end else if (timeout_s) begin
            err_d   = 1'b1;
            state_d = debug_pkg::ST_IDLE;
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d != debug_pkg::ST_IDLE);
    end

    // state, shadow and output registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= debug_pkg::ST_IDLE;
            dest_sh_q <= 16'd0;
            src_sh_q  <= 16'd0;
            dest_q    <= 16'd0;
            src_q     <= 16'd0;
            cnt_q     <= 8'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_sh_q <= dest_sh_d;
            src_sh_q  <= src_sh_d;
            dest_q    <= dest_d;
            src_q     <= src_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign o_rreq        = i_rready;
    assign o_dest_addr   = dest_q;
    assign o_src_addr    = src_q;
    assign o_frame_valid = valid_q;
    assign o_frame_err   = err_q;
    assign o_frame_cnt   = cnt_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_debug_frame_rx.sv
// Scoreboard bench for debug_frame_rx: a byte-stream reference model predicts frame
// events into a queue, and a monitor pops and compares them as the DUT reports them.
module tb_debug_frame_rx;

    localparam int T = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  rdata;
    logic        rready;
    logic        rreq;
    logic [15:0] dest_addr, src_addr;
    logic        frame_valid, frame_err, busy;
    logic [7:0]  frame_cnt;

    debug_frame_rx #(.TIMEOUT_CYCLES(26'd16), .SOF_BYTE(8'h24)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rdata       (rdata),
        .i_rready      (rready),
        .o_rreq        (rreq),
        .o_dest_addr   (dest_addr),
        .o_src_addr    (src_addr),
        .o_frame_valid (frame_valid),
        .o_frame_err   (frame_err),
        .o_frame_cnt   (frame_cnt),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [15:0] dest;
        logic [15:0] src;
        logic [7:0]  cnt;
    } evt_t;

    evt_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   valid_seen = 0;

    // reference model: bytes collected since the opening delimiter
    logic [7:0]  body[4];
    int          nbody = 0;
    bit          in_frame = 0;
    int          gap = 0;
    logic [15:0] m_dest = 16'd0, m_src = 16'd0;
    logic [7:0]  m_cnt = 8'd0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endfunction

    function automatic void push_evt(input bit e);
        evt_t ev;
        ev.is_err = e;
        ev.dest   = m_dest;
        ev.src    = m_src;
        ev.cnt    = m_cnt;
        exp_q.push_back(ev);
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        gap = 0;
        if (!in_frame) begin
            if (b == 8'h24) begin
                in_frame = 1;
                nbody = 0;
            end
        end else if (nbody < 4) begin
            body[nbody] = b;
            nbody++;
        end else begin
            if (b == 8'h24) begin
                m_dest = {body[0], body[1]};
                m_src  = {body[2], body[3]};
                m_cnt  = m_cnt + 8'd1;
                push_evt(0);
            end else begin
                push_evt(1);
            end
            in_frame = 0;
        end
    endfunction

    function automatic void model_idle();
        if (in_frame) begin
            gap++;
            if (gap == T) begin
                push_evt(1);
                in_frame = 0;
                gap = 0;
            end
        end
    endfunction

    // one clock of stimulus; called at posedge+1, returns at the next posedge+1
    task automatic cyc(input bit rdy, input logic [7:0] b);
        rready = rdy;
        rdata  = b;
        if (rdy) model_byte(b);
        else     model_idle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom));
    endtask

    task automatic frame(input logic [15:0] d, input logic [15:0] s, input logic [7:0] eof);
        send(8'h24); send(d[15:8]); send(d[7:0]); send(s[15:8]); send(s[7:0]); send(eof);
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        rready = 1'b0;
        in_frame = 0; gap = 0; nbody = 0;
        m_dest = 16'd0; m_src = 16'd0; m_cnt = 8'd0;
        #1;
        check("rst_outs", {dest_addr, src_addr}, 32'd0);
        check("rst_flags", {frame_cnt, frame_valid, frame_err, busy}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_hold", {frame_cnt, frame_valid, frame_err, busy, 5'd0}, 32'd0);
        rst = 1'b1;
    endtask

    // monitor: every reported frame event must match the next predicted one
    always @(negedge clk) begin
        if (rst && (frame_valid || frame_err)) begin
            check("excl", {31'd0, frame_valid & frame_err}, 32'd0);
            if (frame_valid) valid_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_evt", {31'd0, frame_valid}, 32'd2);
            end else begin
                evt_t ev;
                ev = exp_q.pop_front();
                check("evt_kind", {31'd0, frame_err}, {31'd0, ev.is_err});
                check("evt_dest", {16'd0, dest_addr}, {16'd0, ev.dest});
                check("evt_src", {16'd0, src_addr}, {16'd0, ev.src});
                check("evt_cnt", {24'd0, frame_cnt}, {24'd0, ev.cnt});
            end
        end
    end

    initial begin
        int v0;
        rst = 1'b1; rready = 1'b0; rdata = 8'h00;
        @(posedge clk); #1;
        do_reset();
        check("rreq_low", {31'd0, rreq}, 32'd0);

        // 0A 24 12 34 AB CD 24 0A
        send(8'h0A); frame(16'h1234, 16'hABCD, 8'h24); send(8'h0A);
        idle(2);
        check("f1_dest", {dest_addr, src_addr}, 32'h1234ABCD);
        check("f1_cnt", {24'd0, frame_cnt}, 32'd1);

        frame(16'h2424, 16'h2424, 8'h24);
        idle(2);
        check("f2_addr", {dest_addr, src_addr}, 32'h24242424);

        frame(16'h0102, 16'h0304, 8'h55);
        idle(2);
        check("bad_eof_hold", {dest_addr, src_addr}, 32'h24242424);
        frame(16'h0506, 16'h0708, 8'h24);
        idle(2);
        check("f3_addr", {dest_addr, src_addr}, 32'h05060708);

        // timeout mid-frame, trailing bytes discarded
        send(8'h24); send(8'h01); send(8'h02);
        rready = 1'b1;
        check("rreq_follow", {31'd0, rreq}, 32'd1);
        idle(T);
        idle(1);
        check("to_busy", {31'd0, busy}, 32'd0);
        send(8'h03); send(8'h04);
        idle(2);
        check("to_idle_busy", {31'd0, busy}, 32'd0);
        check("to_hold", {dest_addr, src_addr}, 32'h05060708);

        // gap one short of the limit is tolerated
        send(8'h24); send(8'h11); idle(T - 1); send(8'h22); send(8'h33); send(8'h44); send(8'h24);
        idle(2);
        check("gap_ok", {dest_addr, src_addr}, 32'h11223344);

        // reset mid-frame
        send(8'h24); send(8'hAA);
        do_reset();
        frame(16'hBEEF, 16'hCAFE, 8'h24);
        idle(2);
        check("post_rst", {dest_addr, src_addr}, 32'hBEEFCAFE);
        check("post_rst_cnt", {24'd0, frame_cnt}, 32'd1);

        // 256 back-to-back frames wrap the counter
        do_reset();
        v0 = valid_seen;
        for (int i = 0; i < 256; i++) frame(16'($urandom), 16'($urandom), 8'h24);
        idle(2);
        check("wrap_cnt", {24'd0, frame_cnt}, 32'd0);
        check("wrap_pulses", valid_seen - v0, 32'd256);

        // random mix of good, bad, timed-out frames and junk
        for (int i = 0; i < 300; i++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k < 2) begin
                send(($urandom_range(0, 3) == 0) ? 8'h24 : 8'($urandom));
            end else if (k < 3) begin
                idle($urandom_range(T - 2, T + 2));
            end else begin
                send(8'h24);
                for (int j = 0; j < 4; j++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                    send(($urandom_range(0, 4) == 0) ? 8'h24 : 8'($urandom));
                end
                send(($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h24);
            end
        end
        idle(T + 4);
        check("final_addr", {dest_addr, src_addr}, {m_dest, m_src});
        check("final_cnt", {24'd0, frame_cnt}, {24'd0, m_cnt});
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
